// File: rtl/uart_tx_frame_controller.sv
// UART transmit sequencer: accepts one word by valid/ready, then serialises start, data (LSB first),
// optional parity and stop bits onto a registered TX line with internal baud timing.
module uart_tx_frame_controller #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 SystemClock,
  input  logic                 ResetCounter,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  output logic                 TxLine,
  output logic                 TxBusy,
  output logic                 FrameDone
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [TICK_W-1:0]    r_tick;
  logic [TICK_W-1:0]    w_tick_next;
  logic [BIT_W-1:0]     r_bit;
  logic [BIT_W-1:0]     w_bit_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_tx_line;
  logic                 w_line_next;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_accept;
  logic                 w_bit_end;

  assign w_accept  = (r_state == IDLE) && TxValid;
  assign w_bit_end = (r_state != IDLE) && (r_tick == TICK_LAST);

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    w_state_next  = r_state;
    w_tick_next   = r_tick;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_done_next   = 1'b0;

    if (r_state != IDLE) begin
      w_tick_next = w_bit_end ? '0 : r_tick + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next  = START;
          w_shift_next  = TxData;
          w_parity_next = (^TxData) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_bit == STOP_LAST) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // The bit counter restarts in each state so it serves both data and stop counting.
    if (w_state_next != r_state) w_bit_next = '0;

    case (w_state_next)
      START:   w_line_next = 1'b0;
      DATA:    w_line_next = w_shift_next[0];
      PARITY:  w_line_next = w_parity_next;
      default: w_line_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge SystemClock or negedge ResetCounter) begin
    if (!ResetCounter) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx_line <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tick    <= w_tick_next;
      r_bit     <= w_bit_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx_line <= w_line_next;
      r_busy    <= (w_state_next != IDLE);
      r_done    <= w_done_next;
    end
  end

  assign TxReady   = (r_state == IDLE);
  assign TxLine    = r_tx_line;
  assign TxBusy    = r_busy;
  assign FrameDone = r_done;

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// Directed bench for uart_tx_frame_controller: four parameterisations, table-driven frames plus
// hand-written back-to-back, ignored-valid and mid-frame reset sequences.
module tb_uart_tx_frame_controller;

  localparam int CPB = 4;

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [15:0] bits;   // expected line level per bit time, bit 0 = start bit
    int          nbits;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       tx_line  [4];
  logic       tx_busy  [4];
  logic       frame_done [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame_controller u_dut0 (
    .SystemClock(clk), .ResetCounter(rst_n), .TxData(tx_data[0]), .TxValid(tx_valid[0]),
    .TxReady(tx_ready[0]), .TxLine(tx_line[0]), .TxBusy(tx_busy[0]), .FrameDone(frame_done[0])
  );

  uart_tx_frame_controller #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .SystemClock(clk), .ResetCounter(rst_n), .TxData(tx_data[1]), .TxValid(tx_valid[1]),
    .TxReady(tx_ready[1]), .TxLine(tx_line[1]), .TxBusy(tx_busy[1]), .FrameDone(frame_done[1])
  );

  uart_tx_frame_controller #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .SystemClock(clk), .ResetCounter(rst_n), .TxData(tx_data[2]), .TxValid(tx_valid[2]),
    .TxReady(tx_ready[2]), .TxLine(tx_line[2]), .TxBusy(tx_busy[2]), .FrameDone(frame_done[2])
  );

  uart_tx_frame_controller #(.DATA_BITS(7), .STOP_BITS(2)) u_dut3 (
    .SystemClock(clk), .ResetCounter(rst_n), .TxData(tx_data[3][6:0]), .TxValid(tx_valid[3]),
    .TxReady(tx_ready[3]), .TxLine(tx_line[3]), .TxBusy(tx_busy[3]), .FrameDone(frame_done[3])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a word at a falling edge; returns 1ns after the accepting rising edge.
  task automatic start_frame(input int k, input logic [7:0] d, input bit hold);
    @(negedge clk);
    check($sformatf("ready_before_accept_%0d", k), tx_ready[k], 1'b1);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid[k] = 1'b0;
  endtask

  // Samples every cycle of a frame mid-cycle, then the FrameDone cycle that follows it.
  task automatic watch_frame(input int k, input logic [15:0] bits, input int nbits,
                             input string name, input int inject_at);
    int          n;
    logic [63:0] wave;
    logic [63:0] exp_wave;
    logic [63:0] busy_v;
    bit          ready_seen;
    bit          done_seen;
    n = nbits * CPB;
    wave = '0; exp_wave = '0; busy_v = '0; ready_seen = 1'b0; done_seen = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      wave[c-1]     = tx_line[k];
      exp_wave[c-1] = bits[(c-1)/CPB];
      busy_v[c-1]   = tx_busy[k];
      if (tx_ready[k])   ready_seen = 1'b1;
      if (frame_done[k]) done_seen  = 1'b1;
      if (c == inject_at) begin
        tx_data[k]  = 8'h00;
        tx_valid[k] = 1'b1;
      end else if (c == inject_at + 1) begin
        tx_valid[k] = 1'b0;
      end
    end
    check({name, "_line_wave"}, wave, exp_wave);
    check({name, "_busy_wave"}, busy_v, (64'd1 << n) - 64'd1);
    check({name, "_ready_low"}, ready_seen, 1'b0);
    check({name, "_no_early_done"}, done_seen, 1'b0);
    @(negedge clk);
    check({name, "_done_pulse"}, frame_done[k], 1'b1);
    check({name, "_done_busy"}, tx_busy[k], 1'b0);
    check({name, "_done_ready"}, tx_ready[k], 1'b1);
    check({name, "_done_line"}, tx_line[k], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{0, 8'hA5, 16'h034A, 10, "dflt_A5"};
    vecs[1] = '{0, 8'h00, 16'h0200, 10, "dflt_00"};
    vecs[2] = '{0, 8'hFF, 16'h03FE, 10, "dflt_FF"};
    vecs[3] = '{1, 8'hA5, 16'h054A, 11, "par_even_A5"};
    vecs[4] = '{2, 8'hA5, 16'h074A, 11, "par_odd_A5"};
    vecs[5] = '{1, 8'h01, 16'h0602, 11, "par_even_01"};
    vecs[6] = '{2, 8'h01, 16'h0402, 11, "par_odd_01"};
    vecs[7] = '{3, 8'h41, 16'h0382, 10, "d7s2_41"};

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx_data[k]  = 8'h00;
      tx_valid[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_line_%0d", k),  tx_line[k],    1'b1);
      check($sformatf("rst_ready_%0d", k), tx_ready[k],   1'b1);
      check($sformatf("rst_busy_%0d", k),  tx_busy[k],    1'b0);
      check($sformatf("rst_done_%0d", k),  frame_done[k], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_frame(vecs[i].inst, vecs[i].data, 1'b0);
      watch_frame(vecs[i].inst, vecs[i].bits, vecs[i].nbits, vecs[i].name, -10);
      @(negedge clk);
      check({vecs[i].name, "_done_single"}, frame_done[vecs[i].inst], 1'b0);
      check({vecs[i].name, "_idle_line"},   tx_line[vecs[i].inst],    1'b1);
    end

    // Back-to-back: valid stays high; the second word may only be taken on the FrameDone cycle.
    start_frame(0, 8'h55, 1'b1);
    tx_data[0] = 8'hFF;
    watch_frame(0, 16'h02AA, 10, "b2b_first", -10);
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    watch_frame(0, 16'h03FE, 10, "b2b_second", -10);
    @(negedge clk);
    check("b2b_done_single", frame_done[0], 1'b0);

    // A stray valid during an active frame must not disturb it or queue another frame.
    start_frame(0, 8'hA5, 1'b0);
    watch_frame(0, 16'h034A, 10, "ignored_valid", 10);
    begin
      bit extra;
      extra = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (tx_busy[0] || !tx_line[0] || frame_done[0]) extra = 1'b1;
      end
      check("ignored_no_second_frame", extra, 1'b0);
    end

    // Reset during data bit 3 (cycles 17..20 of the frame) aborts immediately.
    start_frame(0, 8'hA5, 1'b0);
    repeat (18) @(negedge clk);
    check("pre_reset_line_low", tx_line[0], 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_line",  tx_line[0],    1'b1);
    check("rst_mid_busy",  tx_busy[0],    1'b0);
    check("rst_mid_ready", tx_ready[0],   1'b1);
    check("rst_mid_done",  frame_done[0], 1'b0);
    begin
      bit done_seen;
      done_seen = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (frame_done[0] || !tx_line[0] || tx_busy[0]) done_seen = 1'b1;
      end
      check("rst_no_done_after_release", done_seen, 1'b0);
    end
    start_frame(0, 8'h3C, 1'b0);
    watch_frame(0, 16'h0278, 10, "post_reset_3C", -10);
    @(negedge clk);
    check("post_reset_done_single", frame_done[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
